dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory controller between the execute-stage load/store unit and the external data bus. It turns each load/store request (byte, half or word) into one word-aligned bus transaction with byte strobes and runs the request/acknowledge handshake, including wait states and a timeout. It generates the pipeline stall while an access is outstanding and presents right-aligned load data to the write-back stage.

## Interface
- `TIMEOUT`, default 16: maximum number of bus cycles per access, counted from issue, before the access is aborted with an error. Must be ≥ 2.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `stall_in`  in  1  pipeline stall from all other sources; excludes `mem_stall`
- `read_en`  in  1  EX-stage load request
- `write_en`  in  1  EX-stage store request; never asserted together with `read_en`
- `addr`  in  32  byte address from the ALU
- `load_size`  in  2  load size: 00 byte, 01 half, 10 word
- `store_size`  in  2  store size, same encoding
- `store_data`  in  32  store data, zero-extended in the low bits
- `load_data`  out  32  raw loaded data, with the addressed byte or half at bit 0; consumed by the WB stage
- `mem_stall`  out  1  holds the pipeline while an access is in flight
- `misaligned`  out  1  one-cycle pulse when a misaligned request completes
- `bus_err`  out  1  one-cycle pulse when an access is aborted by timeout
- `bus_req`  out  1  bus request
- `bus_we`  out  1  1 = write
- `bus_addr`  out  32  `{addr[31:2], 2'b00}`
- `bus_wdata`  out  32  lane-replicated store data
- `bus_wstrb`  out  4  byte-lane enables; 0000 for reads
- `bus_ack`  in  1  slave completes the transfer this cycle
- `bus_rdata`  in  32  read word; valid only when `bus_ack` is high

## Operation
- **Request.** `req = (read_en | write_en) & ~rst`.
- **Size.** `size` is `store_size` when `write_en` is high, otherwise `load_size`.
- **Misalignment.** A request is misaligned when it is a half access with `addr[0]` set, or a word access with `addr[1:0]` nonzero. A misaligned request:
  - issues no bus cycle;
  - completes immediately with `misaligned` high;
  - writes `load_data` = 0 if it is a load.
- **Store lanes.**
  - Byte: `bus_wdata` = `{4{store_data[7:0]}}`, `bus_wstrb` = `0001 << addr[1:0]`.
  - Half: `bus_wdata` = `{2{store_data[15:0]}}`, `bus_wstrb` = `0011 << {addr[1],1'b0}`.
  - Word: `bus_wdata` = `store_data`, `bus_wstrb` = 1111.
- **Load alignment.** `load_data` = `rdata >> (8*addr[1:0])`, filled with zeros from the top. Sign or zero extension is done downstream.
- **States:**
  - **IDLE.** An aligned `req` drives the bus combinationally from the EX inputs and clears the cycle counter.
    - `bus_ack` → completion.
    - Otherwise → WAIT, latching `bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb`, `addr[1:0]` and the load flag.
  - **WAIT.** `bus_req` is held from the latched values; the bus outputs are stable until ack or abort. The counter increments each cycle.
    - `bus_ack` → completion.
    - Otherwise, when the counter reaches `TIMEOUT-1` → completion with `bus_err`; `bus_req` is low from the next cycle.
    - `bus_ack` wins over timeout in the same cycle.
  - **DONE.** The access completed while `stall_in` was high. `bus_req` is 0, so the EX instruction is not re-issued. Go to IDLE on the first cycle `stall_in` is low.
- **Completion.**
  - If `stall_in` is low, the pipeline advances this edge and the next state is IDLE.
  - Otherwise the next state is DONE, and the aligned read word is captured into `rdata_buf`.
- **`load_data` update.** `load_data` updates only on an advancing edge (`~stall_in & ~mem_stall`) whose EX instruction is a load. The source is the aligned `bus_rdata` when ack arrives that cycle, otherwise `rdata_buf`. This protects an older load sitting in WB during an external stall.
- **`mem_stall`** = `(IDLE & aligned req & ~bus_ack) | (WAIT & ~bus_ack & ~timeout)`.

## Timing
- Reset values:
  - state = IDLE, counter = 0;
  - `load_data`, `rdata_buf` = 0;
  - `misaligned`, `bus_err` = 0;
  - all `bus_*` outputs = 0.
- Outputs are forced to 0 in any cycle `rst` is high. Reset during WAIT drops `bus_req` in that same cycle and goes to IDLE.
- Zero-wait slave (ack in the issue cycle): no stall. `load_data` is valid in the next cycle, i.e. the load's WB cycle.
- N wait cycles: `mem_stall` is high for N cycles; `load_data` is valid the cycle after ack.
- Timeout: `mem_stall` is high for `TIMEOUT-1` cycles, then `bus_err` pulses in the abort cycle.
- `misaligned` and `bus_err` are combinational in the completion cycle, lasting one cycle. In DONE they are not repeated.
- Back-to-back accesses: a new request can issue in the cycle after completion.

## Structure
- Shared package `mem_utils`:
  - size encoding constants `SIZE_B`, `SIZE_H`, `SIZE_W`;
  - state enum `dmem_state_e {IDLE, WAIT, DONE}`.
- Sub-module `dmem_align`: combinational; store lane/strobe generation, load right-shift and misalignment detect. Instantiated once for the EX path; the read shift uses the latched offset in WAIT.

## Test plan
- **SB, zero-wait.** SB at `addr` 0x1003, `store_data` 0xAB, ack same cycle → `bus_addr` 0x1000, `bus_wdata` 0xABABABAB, `bus_wstrb` 1000, `mem_stall` never high.
- **LH, two waits.** LH at 0x2002, ack after 2 wait cycles with `bus_rdata` 0xBEEF1234 → `mem_stall` high for 2 cycles, `bus_*` stable, `load_data` 0x0000BEEF the cycle after ack.
- **Misaligned SW.** SW at 0x3001 → no `bus_req`, `misaligned` pulses 1 cycle, no stall.
- **Timeout.** LW with `TIMEOUT` 4 and no ack → `mem_stall` high for 3 cycles, `bus_err` pulse in the 4th, `bus_req` low after.
- **External stall.** LW acks 0xCAFEF00D while `stall_in` is high for 3 cycles → no re-issue (DONE state), `load_data` unchanged until `stall_in` drops, then 0xCAFEF00D.
- **Reset mid-access.** `rst` asserted in WAIT → `bus_req` low the same cycle, state IDLE, `load_data` 0.

Source files
------------

// File: rtl/mem_utils_pkg.sv
// Shared memory-path definitions: access size encoding and the
// data-memory controller state enum.
package mem_utils;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dmem_state_e;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: store replication/strobes, load
// right-alignment and misalignment detection.
module dmem_align
    import mem_utils::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  rd_off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] rdata_al,
    output logic        misaligned
);

    always_comb begin
        wdata      = store_data;
        wstrb      = 4'b1111;
        misaligned = 1'b0;
        case (size)
            SIZE_B: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            SIZE_H: begin
                wdata      = {2{store_data[15:0]}};
                wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

    assign rdata_al = rdata >> {rd_off, 3'b000};

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one word-aligned bus transaction per
// load/store, with wait states, timeout and pipeline stall.
module dmem_ctrl
    import mem_utils::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] addr,
    input  logic [1:0]  load_size,
    input  logic [1:0]  store_size,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        mem_stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    dmem_state_e state, state_nxt;
    logic [CW-1:0] cnt;

    logic        we_q, load_q;
    logic [31:0] addr_q, wdata_q, rdata_buf, ld_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  off_q;

    logic        req, mis, issue, in_wait, ack_c, tmo, done_c, adv, is_load;
    logic [1:0]  size, rd_off;
    logic [31:0] al_wdata, rdata_al, ld_src;
    logic [3:0]  al_wstrb;

    assign req     = (read_en | write_en) & ~rst;
    assign size    = write_en ? store_size : load_size;
    assign in_wait = (state == WAIT) & ~rst;
    assign rd_off  = (state == WAIT) ? off_q : addr[1:0];

    dmem_align u_align (
        .size       (size),
        .addr_lo    (addr[1:0]),
        .rd_off     (rd_off),
        .store_data (store_data),
        .rdata      (bus_rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .rdata_al   (rdata_al),
        .misaligned (mis)
    );

    assign issue  = (state == IDLE) & req & ~mis;
    assign ack_c  = (issue | in_wait) & bus_ack;
    assign tmo    = in_wait & (cnt == CW'(TIMEOUT - 1));
    assign done_c = ((state == IDLE) & req & (mis | bus_ack))
                  | (in_wait & (bus_ack | tmo));

    assign mem_stall  = (issue & ~bus_ack) | (in_wait & ~bus_ack & ~tmo);
    assign misaligned = (state == IDLE) & req & mis;
    assign bus_err    = tmo & ~bus_ack;
    assign adv        = ~stall_in & ~mem_stall;
    assign is_load    = (state == IDLE) ? read_en : load_q;
    assign load_data  = rst ? 32'h0 : ld_q;

    // Aborted and misaligned accesses return zero rather than bus garbage.
    assign ld_src = ack_c ? rdata_al :
                    (state == DONE) ? rdata_buf : 32'h0;

    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        bus_wstrb = 4'b0000;
        if (issue) begin
            bus_req   = 1'b1;
            bus_we    = write_en;
            bus_addr  = {addr[31:2], 2'b00};
            bus_wdata = write_en ? al_wdata : 32'h0;
            bus_wstrb = write_en ? al_wstrb : 4'b0000;
        end else if (in_wait) begin
            bus_req   = 1'b1;
            bus_we    = we_q;
            bus_addr  = addr_q;
            bus_wdata = wdata_q;
            bus_wstrb = wstrb_q;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue & ~bus_ack) state_nxt = WAIT;
                else if (done_c)      state_nxt = stall_in ? DONE : IDLE;
            end
            WAIT: begin
                if (done_c) state_nxt = stall_in ? DONE : IDLE;
            end
            DONE: begin
                if (~stall_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            load_q    <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'b0000;
            off_q     <= 2'b00;
            rdata_buf <= 32'h0;
            ld_q      <= 32'h0;
        end else begin
            state <= state_nxt;
            // The issue cycle itself counts as the first bus cycle.
            if (issue) begin
                cnt     <= CW'(1);
                we_q    <= bus_we;
                addr_q  <= bus_addr;
                wdata_q <= bus_wdata;
                wstrb_q <= bus_wstrb;
                off_q   <= addr[1:0];
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if ((state == IDLE) & req) load_q <= read_en;
            if (done_c & stall_in) rdata_buf <= ack_c ? rdata_al : 32'h0;
            if (adv & is_load) ld_q <= ld_src;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (TIMEOUT = 4).
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall_in, read_en, write_en;
    logic [31:0] addr, store_data, bus_rdata;
    logic [1:0]  load_size, store_size;
    logic        bus_ack;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic        mem_stall, misaligned, bus_err, bus_req, bus_we;
    logic [3:0]  bus_wstrb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_in   (stall_in),
        .read_en    (read_en),
        .write_en   (write_en),
        .addr       (addr),
        .load_size  (load_size),
        .store_size (store_size),
        .store_data (store_data),
        .load_data  (load_data),
        .mem_stall  (mem_stall),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    task automatic idle_inputs();
        stall_in   = 1'b0;
        read_en    = 1'b0;
        write_en   = 1'b0;
        addr       = 32'h0;
        load_size  = 2'b00;
        store_size = 2'b00;
        store_data = 32'h0;
        bus_ack    = 1'b0;
        bus_rdata  = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        read_en = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({bus_req, mem_stall, misaligned, bus_err, load_data} !== 36'h0) begin
            failures++;
            $display("FAIL rst_outputs got=%h exp=0",
                     {bus_req, mem_stall, misaligned, bus_err, load_data});
        end
        next_cycle();
        rst = 1'b0;
        read_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, load_data} !== 102'h0) begin
            failures++;
            $display("FAIL post_rst got req=%b ld=%h exp 0", bus_req, load_data);
        end
        next_cycle();
    endtask

    task automatic test_sb_zero_wait();
        write_en   = 1'b1;
        store_size = 2'b00;
        addr       = 32'h1003;
        store_data = 32'hAB;
        bus_ack    = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, mem_stall}
            !== {1'b1, 1'b1, 32'h1000, 32'hABABABAB, 4'b1000, 1'b0}) begin
            failures++;
            $display("FAIL sb_bus got a=%h d=%h s=%b st=%b exp a=1000 d=abababab s=1000 st=0",
                     bus_addr, bus_wdata, bus_wstrb, mem_stall);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({bus_req, mem_stall} !== 2'b00) begin
            failures++;
            $display("FAIL sb_after got req=%b st=%b exp 0 0", bus_req, mem_stall);
        end
        next_cycle();
    endtask

    task automatic test_lh_wait();
        read_en   = 1'b1;
        load_size = 2'b01;
        addr      = 32'h2002;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_stall, bus_req, bus_we, bus_addr, bus_wstrb}
                !== {1'b1, 1'b1, 1'b0, 32'h2000, 4'b0000}) begin
                failures++;
                $display("FAIL lh_wait%0d got st=%b req=%b a=%h exp st=1 req=1 a=2000",
                         i, mem_stall, bus_req, bus_addr);
            end
            next_cycle();
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'hBEEF1234;
        @(negedge clk);
        checks++;
        if ({mem_stall, bus_req, bus_addr, load_data} !== {1'b0, 1'b1, 32'h2000, 32'h0}) begin
            failures++;
            $display("FAIL lh_ack got st=%b req=%b a=%h ld=%h exp 0 1 2000 0",
                     mem_stall, bus_req, bus_addr, load_data);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (load_data !== 32'h0000BEEF) begin
            failures++;
            $display("FAIL lh_data got=%h exp=0000beef", load_data);
        end
        next_cycle();
    endtask

    task automatic test_misaligned();
        write_en   = 1'b1;
        store_size = 2'b10;
        addr       = 32'h3001;
        store_data = 32'h55667788;
        @(negedge clk);
        checks++;
        if ({bus_req, misaligned, mem_stall} !== 3'b010) begin
            failures++;
            $display("FAIL mis_sw got req=%b mis=%b st=%b exp 0 1 0",
                     bus_req, misaligned, mem_stall);
        end
        next_cycle();
        idle_inputs();
        read_en   = 1'b1;
        load_size = 2'b10;
        addr      = 32'h5002;
        @(negedge clk);
        checks++;
        if ({bus_req, misaligned, mem_stall} !== 3'b010) begin
            failures++;
            $display("FAIL mis_lw got req=%b mis=%b st=%b exp 0 1 0",
                     bus_req, misaligned, mem_stall);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({misaligned, load_data} !== 33'h0) begin
            failures++;
            $display("FAIL mis_lw_after got mis=%b ld=%h exp 0 0", misaligned, load_data);
        end
        next_cycle();
    endtask

    task automatic test_lb_zero_wait();
        read_en   = 1'b1;
        load_size = 2'b00;
        addr      = 32'h6001;
        bus_ack   = 1'b1;
        bus_rdata = 32'h11223344;
        @(negedge clk);
        checks++;
        if ({bus_req, mem_stall, bus_addr} !== {1'b1, 1'b0, 32'h6000}) begin
            failures++;
            $display("FAIL lb_bus got req=%b st=%b a=%h exp 1 0 6000",
                     bus_req, mem_stall, bus_addr);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (load_data !== 32'h00112233) begin
            failures++;
            $display("FAIL lb_data got=%h exp=00112233", load_data);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        read_en   = 1'b1;
        load_size = 2'b10;
        addr      = 32'h4000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_stall, bus_err, bus_req} !== 3'b101) begin
                failures++;
                $display("FAIL tmo_wait%0d got st=%b err=%b req=%b exp 1 0 1",
                         i, mem_stall, bus_err, bus_req);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if ({mem_stall, bus_err} !== 2'b01) begin
            failures++;
            $display("FAIL tmo_abort got st=%b err=%b exp 0 1", mem_stall, bus_err);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({bus_req, bus_err, mem_stall} !== 3'b000) begin
            failures++;
            $display("FAIL tmo_after got req=%b err=%b st=%b exp 0 0 0",
                     bus_req, bus_err, mem_stall);
        end
        next_cycle();
    endtask

    task automatic test_ext_stall();
        // Seed load_data with a known value first.
        test_lb_zero_wait();
        read_en   = 1'b1;
        load_size = 2'b10;
        addr      = 32'h7000;
        stall_in  = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if ({bus_req, mem_stall} !== 2'b10) begin
            failures++;
            $display("FAIL xs_issue got req=%b st=%b exp 1 0", bus_req, mem_stall);
        end
        next_cycle();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) stall_in = 1'b0;
            @(negedge clk);
            checks++;
            if ({bus_req, mem_stall, load_data} !== {1'b0, 1'b0, 32'h00112233}) begin
                failures++;
                $display("FAIL xs_hold%0d got req=%b st=%b ld=%h exp 0 0 00112233",
                         i, bus_req, mem_stall, load_data);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({bus_req, load_data} !== {1'b0, 32'hCAFEF00D}) begin
            failures++;
            $display("FAIL xs_data got req=%b ld=%h exp 0 cafef00d", bus_req, load_data);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        read_en   = 1'b1;
        load_size = 2'b10;
        addr      = 32'h8000;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_req, mem_stall, load_data} !== 34'h0) begin
            failures++;
            $display("FAIL rmid_same got req=%b st=%b ld=%h exp 0 0 0",
                     bus_req, mem_stall, load_data);
        end
        next_cycle();
        rst = 1'b0;
        read_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_req, mem_stall, load_data} !== 34'h0) begin
            failures++;
            $display("FAIL rmid_after got req=%b st=%b ld=%h exp 0 0 0",
                     bus_req, mem_stall, load_data);
        end
        next_cycle();
        // A fresh request issues straight from IDLE.
        read_en = 1'b1;
        addr    = 32'h8100;
        bus_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_req, mem_stall, bus_addr} !== {1'b1, 1'b0, 32'h8100}) begin
            failures++;
            $display("FAIL rmid_reissue got req=%b st=%b a=%h exp 1 0 8100",
                     bus_req, mem_stall, bus_addr);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        write_en   = 1'b1;
        store_size = 2'b10;
        addr       = 32'h9004;
        store_data = 32'h12345678;
        bus_ack    = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_req, bus_addr, bus_wdata, bus_wstrb}
            !== {1'b1, 32'h9004, 32'h12345678, 4'b1111}) begin
            failures++;
            $display("FAIL b2b_sw got a=%h d=%h s=%b exp 9004 12345678 1111",
                     bus_addr, bus_wdata, bus_wstrb);
        end
        next_cycle();
        store_size = 2'b01;
        addr       = 32'h900A;
        store_data = 32'hBEEF;
        @(negedge clk);
        checks++;
        if ({bus_req, mem_stall, bus_addr, bus_wdata, bus_wstrb}
            !== {1'b1, 1'b0, 32'h9008, 32'hBEEFBEEF, 4'b1100}) begin
            failures++;
            $display("FAIL b2b_sh got a=%h d=%h s=%b exp 9008 beefbeef 1100",
                     bus_addr, bus_wdata, bus_wstrb);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_sb_zero_wait();
        test_lh_wait();
        test_misaligned();
        test_timeout();
        test_ext_stall();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
